// File: rtl/test_seq_controller.sv
// test_seq_controller: bench-side reset sequencer and end-of-test arbiter.
// Releases core, UART and ADC resets in order, then counts run cycles and
// judges pass/fail from the harness success flag, timeout or abort.
// Optional macro TEST_SEQ_HEARTBEAT_EN adds a heartbeat_o toggle output.
// Handshakes: start_i and abort_i are levels sampled on rising clock_i;
// clear_i is a pulse honoured only in PASS/FAIL; all outputs are registered.
module test_seq_controller #(
   parameter int HOLD_CYCLES = 16,
   parameter int STAGE_GAP   = 8,
   parameter int CNT_W       = 64,
   parameter int HB_LOG2     = 10
) (
   input  logic             clock_i,
   input  logic             reset_i,
   input  logic             start_i,
   input  logic             abort_i,
   input  logic             clear_i,
   input  logic [CNT_W-1:0] max_cycles_i,
   input  logic             success_i,
   output logic             core_reset_o,
   output logic             ua_reset_o,
   output logic             adc_reset_o,
   output logic             running_o,
   output logic [CNT_W-1:0] cycle_count_o,
   output logic             done_o,
   output logic             failed_o,
   output logic [1:0]       fail_code_o,
`ifdef TEST_SEQ_HEARTBEAT_EN
   output logic             heartbeat_o,
`endif
   output logic [2:0]       state_o
);

   localparam int MAXC = (HOLD_CYCLES > STAGE_GAP) ? HOLD_CYCLES : STAGE_GAP;
   localparam int DW   = (MAXC > 1) ? $clog2(MAXC) : 1;

   // Reject parameter values the sequencing cannot honour.
   if (HOLD_CYCLES < 1 || STAGE_GAP < 1 || HB_LOG2 < 1 || HB_LOG2 > CNT_W) begin : g_bad_param
      $error("test_seq_controller: illegal parameter value");
   end

   typedef enum logic [2:0] {
      S_IDLE    = 3'd0,
      S_HOLD    = 3'd1,
      S_STG_UA  = 3'd2,
      S_STG_ADC = 3'd3,
      S_RUN     = 3'd4,
      S_PASS    = 3'd5,
      S_FAIL    = 3'd6
   } state_e;

   state_e           state_q, state_d;
   logic [DW-1:0]    dcnt_q, dcnt_d;
   logic [CNT_W-1:0] limit_q, limit_d;
   logic [CNT_W-1:0] cycle_q, cycle_d;
   logic             core_q, core_d;
   logic             ua_q, ua_d;
   logic             adc_q, adc_d;
   logic             running_q, running_d;
   logic             done_q, done_d;
   logic             failed_q, failed_d;
   logic [1:0]       code_q, code_d;
   logic [CNT_W-1:0] cycle_inc;
`ifdef TEST_SEQ_HEARTBEAT_EN
   logic             hb_q, hb_d;
`endif

   // Next-state, counters and registered output values.
   always_comb begin
      state_d   = state_q;
      dcnt_d    = dcnt_q;
      limit_d   = limit_q;
      cycle_d   = cycle_q;
      core_d    = core_q;
      ua_d      = ua_q;
      adc_d     = adc_q;
      code_d    = code_q;
      cycle_inc = (cycle_q == '1) ? cycle_q : cycle_q + 1'b1;
`ifdef TEST_SEQ_HEARTBEAT_EN
      hb_d      = hb_q;
`endif
      unique case (state_q)
         S_IDLE: begin
            core_d = 1'b1;
            ua_d   = 1'b1;
            adc_d  = 1'b1;
            code_d = 2'd0;
            if (start_i) begin
               limit_d = max_cycles_i;
               dcnt_d  = DW'(HOLD_CYCLES - 1);
               state_d = S_HOLD;
            end
         end
         S_HOLD, S_STG_UA, S_STG_ADC: begin
            if (abort_i) begin
               core_d  = 1'b1;
               ua_d    = 1'b1;
               adc_d   = 1'b1;
               code_d  = 2'd3;
               state_d = S_FAIL;
            end else if (success_i) begin
               code_d  = 2'd2;
               state_d = S_FAIL;
            end else if (dcnt_q != '0) begin
               dcnt_d = dcnt_q - 1'b1;
            end else begin
               dcnt_d = DW'(STAGE_GAP - 1);
               if (state_q == S_HOLD) begin
                  core_d  = 1'b0;
                  state_d = S_STG_UA;
               end else if (state_q == S_STG_UA) begin
                  ua_d    = 1'b0;
                  state_d = S_STG_ADC;
               end else begin
                  adc_d   = 1'b0;
                  cycle_d = '0;
                  state_d = S_RUN;
               end
            end
         end
         S_RUN: begin
            if (abort_i) begin
               core_d  = 1'b1;
               ua_d    = 1'b1;
               adc_d   = 1'b1;
               code_d  = 2'd3;
               state_d = S_FAIL;
            end else if (success_i) begin
               state_d = S_PASS;
            end else if (limit_q != '0 && cycle_q == limit_q) begin
               code_d  = 2'd1;
               state_d = S_FAIL;
            end else begin
               cycle_d = cycle_inc;
`ifdef TEST_SEQ_HEARTBEAT_EN
               if (cycle_q != '1 && cycle_inc[HB_LOG2-1:0] == '0) hb_d = ~hb_q;
`endif
            end
         end
         S_PASS, S_FAIL: begin
            if (clear_i) begin
               core_d  = 1'b1;
               ua_d    = 1'b1;
               adc_d   = 1'b1;
               code_d  = 2'd0;
               state_d = S_IDLE;
            end
         end
         default: state_d = S_IDLE;
      endcase
      running_d = (state_d == S_RUN);
      done_d    = (state_d == S_PASS) || (state_d == S_FAIL);
      failed_d  = (state_d == S_FAIL);
   end

   // State and output registers with asynchronous active-low reset.
   always_ff @(posedge clock_i or negedge reset_i) begin
      if (!reset_i) begin
         state_q   <= S_IDLE;
         dcnt_q    <= '0;
         limit_q   <= '0;
         cycle_q   <= '0;
         core_q    <= 1'b1;
         ua_q      <= 1'b1;
         adc_q     <= 1'b1;
         running_q <= 1'b0;
         done_q    <= 1'b0;
         failed_q  <= 1'b0;
         code_q    <= 2'd0;
`ifdef TEST_SEQ_HEARTBEAT_EN
         hb_q      <= 1'b0;
`endif
      end else begin
         state_q   <= state_d;
         dcnt_q    <= dcnt_d;
         limit_q   <= limit_d;
         cycle_q   <= cycle_d;
         core_q    <= core_d;
         ua_q      <= ua_d;
         adc_q     <= adc_d;
         running_q <= running_d;
         done_q    <= done_d;
         failed_q  <= failed_d;
         code_q    <= code_d;
`ifdef TEST_SEQ_HEARTBEAT_EN
         hb_q      <= hb_d;
`endif
      end
   end

   assign core_reset_o  = core_q;
   assign ua_reset_o    = ua_q;
   assign adc_reset_o   = adc_q;
   assign running_o     = running_q;
   assign cycle_count_o = cycle_q;
   assign done_o        = done_q;
   assign failed_o      = failed_q;
   assign fail_code_o   = code_q;
   assign state_o       = state_q;
`ifdef TEST_SEQ_HEARTBEAT_EN
   assign heartbeat_o   = hb_q;
`endif

endmodule

// File: tb/tb_test_seq_controller.sv
// tb_test_seq_controller: directed bench for test_seq_controller
// (HOLD_CYCLES=16, STAGE_GAP=8, HB_LOG2=4). Build with
// TEST_SEQ_HEARTBEAT_EN defined to also check heartbeat_o.
module tb_test_seq_controller;

   localparam int CNT_W = 64;

   logic             clk;
   logic             rst_n;
   logic             start;
   logic             abort;
   logic             clear;
   logic [CNT_W-1:0] max_cycles;
   logic             success;
   logic             core_reset;
   logic             ua_reset;
   logic             adc_reset;
   logic             running;
   logic [CNT_W-1:0] cycle_count;
   logic             done;
   logic             failed;
   logic [1:0]       fail_code;
   logic [2:0]       state;
`ifdef TEST_SEQ_HEARTBEAT_EN
   logic             heartbeat;
`endif

   int tests = 0;
   int fails = 0;

   test_seq_controller #(
      .HOLD_CYCLES(16),
      .STAGE_GAP  (8),
      .CNT_W      (CNT_W),
      .HB_LOG2    (4)
   ) dut (
      .clock_i      (clk),
      .reset_i      (rst_n),
      .start_i      (start),
      .abort_i      (abort),
      .clear_i      (clear),
      .max_cycles_i (max_cycles),
      .success_i    (success),
      .core_reset_o (core_reset),
      .ua_reset_o   (ua_reset),
      .adc_reset_o  (adc_reset),
      .running_o    (running),
      .cycle_count_o(cycle_count),
      .done_o       (done),
      .failed_o     (failed),
      .fail_code_o  (fail_code),
`ifdef TEST_SEQ_HEARTBEAT_EN
      .heartbeat_o  (heartbeat),
`endif
      .state_o      (state)
   );

   // Clock generation.
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Advance n rising edges, then settle 1 time unit past the edge.
   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: got %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic check_resets(input string tag, input logic c, input logic u, input logic a);
      check({tag, ".core"}, core_reset, c);
      check({tag, ".ua"}, ua_reset, u);
      check({tag, ".adc"}, adc_reset, a);
   endtask

   task automatic check_flags(input string tag, input logic r, input logic d, input logic f, input logic [1:0] code);
      check({tag, ".running"}, running, r);
      check({tag, ".done"}, done, d);
      check({tag, ".failed"}, failed, f);
      check({tag, ".code"}, fail_code, code);
   endtask

   // Pulse clear for one edge.
   task automatic do_clear();
      clear = 1'b1;
      tick(1);
      clear = 1'b0;
   endtask

   // Start a sequence; returns just after edge 0 (start sampled).
   task automatic do_start(input logic [CNT_W-1:0] lim);
      max_cycles = lim;
      start      = 1'b1;
      tick(1);
      start      = 1'b0;
   endtask

   initial begin
      rst_n      = 1'b0;
      start      = 1'b0;
      abort      = 1'b0;
      clear      = 1'b0;
      success    = 1'b0;
      max_cycles = '0;
      tick(3);
      check_resets("rst", 1, 1, 1);
      check_flags("rst", 0, 0, 0, 2'd0);
      check("rst.count", cycle_count, 0);
`ifdef TEST_SEQ_HEARTBEAT_EN
      check("rst.hb", heartbeat, 0);
`endif
      @(negedge clk);
      rst_n = 1'b1;
      tick(1);

      // Async reset mid-sequence (after ua release, before adc release).
      do_start(0);
      tick(27);
      check_resets("s6.pre", 0, 0, 1);
      #3;
      rst_n = 1'b0;
      #1;
      check_resets("s6.async", 1, 1, 1);
      check_flags("s6.async", 0, 0, 0, 2'd0);
      @(negedge clk);
      rst_n = 1'b1;
      tick(1);
      check_resets("s6.idle", 1, 1, 1);

      // Restart after reset; check heartbeat toggles every 16 run cycles.
      do_start(0);
      tick(32);
      check("s6.run", running, 1);
      check("s6.cnt0", cycle_count, 0);
      tick(15);
      check("s6.cnt15", cycle_count, 15);
`ifdef TEST_SEQ_HEARTBEAT_EN
      check("s6.hb15", heartbeat, 0);
`endif
      tick(1);
`ifdef TEST_SEQ_HEARTBEAT_EN
      check("s6.hb16", heartbeat, 1);
`endif
      tick(15);
`ifdef TEST_SEQ_HEARTBEAT_EN
      check("s6.hb31", heartbeat, 1);
`endif
      tick(1);
      check("s6.cnt32", cycle_count, 32);
`ifdef TEST_SEQ_HEARTBEAT_EN
      check("s6.hb32", heartbeat, 0);
`endif
      abort = 1'b1;
      tick(1);
      abort = 1'b0;
      do_clear();

      // Scenario 1: ordered release, success at run cycle 100.
      do_start(0);
      tick(15);
      check_resets("s1.e15", 1, 1, 1);
      tick(1);
      check_resets("s1.e16", 0, 1, 1);
      tick(7);
      check_resets("s1.e23", 0, 1, 1);
      tick(1);
      check_resets("s1.e24", 0, 0, 1);
      check("s1.e24.run", running, 0);
      tick(8);
      check_resets("s1.e32", 0, 0, 0);
      check_flags("s1.e32", 1, 0, 0, 2'd0);
      check("s1.e32.cnt", cycle_count, 0);
      tick(100);
      check("s1.cnt100", cycle_count, 100);
      success = 1'b1;
      tick(1);
      success = 1'b0;
      check_flags("s1.pass", 0, 1, 0, 2'd0);
      check("s1.pass.cnt", cycle_count, 100);
      tick(5);
      check_resets("s1.sticky", 0, 0, 0);
      check("s1.sticky.done", done, 1);
      check("s1.frozen", cycle_count, 100);
      abort = 1'b1;
      tick(1);
      abort = 1'b0;
      check_flags("s1.abort_ignored", 0, 1, 0, 2'd0);
      do_clear();
      check_resets("s1.clear", 1, 1, 1);
      check_flags("s1.clear", 0, 0, 0, 2'd0);
      check("s1.clear.cnt", cycle_count, 100);

      // Scenario 2: timeout at 50; limit latched on leaving IDLE.
      do_start(50);
      max_cycles = '0;
      tick(32);
      tick(50);
      check("s2.cnt50", cycle_count, 50);
      check("s2.run50", running, 1);
      tick(1);
      check_flags("s2.fail", 0, 1, 1, 2'd1);
      check("s2.cnt", cycle_count, 50);
      check_resets("s2.fail", 0, 0, 0);
      do_clear();

      // Scenario 3: premature success in STG_UA.
      do_start(0);
      tick(19);
      success = 1'b1;
      tick(1);
      success = 1'b0;
      check_flags("s3.fail", 0, 1, 1, 2'd2);
      check_resets("s3.fail", 0, 1, 1);
      tick(20);
      check("s3.norun", running, 0);
      check("s3.adc", adc_reset, 1);
      do_clear();

      // Scenario 4: success and timeout in the same cycle -> PASS.
      do_start(50);
      tick(32);
      tick(50);
      success = 1'b1;
      tick(1);
      success = 1'b0;
      check_flags("s4.pass", 0, 1, 0, 2'd0);
      check("s4.cnt", cycle_count, 50);
      do_clear();

      // Scenario 5: abort in RUN, clear with start held, full repeat.
      do_start(0);
      tick(32);
      tick(10);
      check("s5.cnt10", cycle_count, 10);
      abort   = 1'b1;
      success = 1'b1;
      tick(1);
      abort   = 1'b0;
      success = 1'b0;
      check_flags("s5.fail", 0, 1, 1, 2'd3);
      check_resets("s5.fail", 1, 1, 1);
      check("s5.cnt", cycle_count, 10);
      start = 1'b1;
      clear = 1'b1;
      tick(1);
      clear = 1'b0;
      check_flags("s5.clear", 0, 0, 0, 2'd0);
      check("s5.idle", state, 0);
      check("s5.keep", cycle_count, 10);
      tick(1);
      start = 1'b0;
      check("s5.hold", state, 1);
      tick(15);
      check_resets("s5.e15", 1, 1, 1);
      tick(1);
      check_resets("s5.e16", 0, 1, 1);
      tick(16);
      check_resets("s5.e32", 0, 0, 0);
      check("s5.run", running, 1);
      check("s5.cnt0", cycle_count, 0);
      tick(5);
      check("s5.cnt5", cycle_count, 5);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
